// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the IF/MEM memory port arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, DATA, FETCH, RESP} state_e;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam int TMR_W = 16;
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: wait-cycle counter flagging when an access has waited TIMEOUT cycles
module mem_wait_timer
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  logic [TMR_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expired_o = cnt_q == TMR_W'(TIMEOUT - 1);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory port between fetch and load/store
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] NOP_INSTR = NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        dm_read,
  input  logic        dm_write,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        err
);
  state_e      state_q, state_d;
  logic        req_q, req_d, we_q, we_d, err_q, err_d;
  logic        if_valid_q, if_valid_d, dm_done_q, dm_done_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic        busy, expired;

  assign busy = state_q == DATA || state_q == FETCH;

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk,
    .rst,
    .clr_i    (~busy),
    .en_i     (~mem_ack),
    .expired_o(expired)
  );

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = 1'b0;
    if_valid_d = 1'b0;
    dm_done_d  = 1'b0;
    case (state_q)
      IDLE:
        if (dm_read | dm_write) begin
          state_d = DATA;
          req_d   = 1'b1;
          we_d    = dm_write;
          addr_d  = dm_addr;
          wdata_d = dm_wdata;
        end else if (if_req) begin
          state_d = FETCH;
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = if_addr;
        end
      DATA, FETCH:
        // ack on the expiry cycle still counts as a normal completion
        if (mem_ack | expired) begin
          state_d    = RESP;
          req_d      = 1'b0;
          err_d      = ~mem_ack;
          rdata_d    = mem_ack ? (we_q ? '0 : mem_rdata) : (state_q == FETCH ? NOP_INSTR : '0);
          dm_done_d  = state_q == DATA;
          if_valid_d = state_q == FETCH;
        end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      if_valid_q <= 1'b0;
      dm_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      if_valid_q <= if_valid_d;
      dm_done_q  <= dm_done_d;
    end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_rdata  = rdata_q;
  assign dm_rdata  = rdata_q;
  assign if_valid  = if_valid_q;
  assign dm_done   = dm_done_q;
  assign err       = err_q;
  // stalls are forced low during reset so the pipeline is not held by a stale request
  assign stall_mem = ~rst & (dm_read | dm_write) & ~dm_done_q;
  assign stall_if  = ~rst & ((if_req & ~if_valid_q) | stall_mem);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized transaction-level check of the memory port arbiter
module tb_mem_port_arbiter;
  localparam int          TO   = 4;
  localparam logic [31:0] NOPW = 32'h00000013;

  logic        clk = 1'b0, rst = 1'b1;
  logic        if_req = 1'b0, dm_read = 1'b0, dm_write = 1'b0, mem_ack = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rdata = '0;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_valid, dm_done, mem_req, mem_we, stall_if, stall_mem, err;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_if(stall_if), .stall_mem(stall_mem), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, act, exp);
    end
  endtask

  // One access from issue to response; ack arrives ackdly wait cycles after mem_req rises
  task automatic serve(input bit is_fetch, input bit we, input logic [31:0] addr,
                       input logic [31:0] wd, input int ackdly, input logic [31:0] val);
    int          c = 0;
    bit          done = 1'b0;
    bit          to = ackdly >= TO;
    logic [31:0] exp_d;
    exp_d = is_fetch ? (to ? NOPW : val) : ((we || to) ? 32'h0 : val);
    @(negedge clk);
    chk("issue_addr", mem_addr, addr);
    chk("issue_we", 32'(mem_we), 32'(we));
    if (we) chk("issue_wdata", mem_wdata, wd);
    while (!done && c <= TO + 2) begin
      chk("req_held", 32'(mem_req), 32'd1);
      chk("addr_stable", mem_addr, addr);
      chk("we_stable", 32'(mem_we), 32'(we));
      chk("stall_mem", 32'(stall_mem), 32'(!is_fetch));
      chk("stall_if", 32'(stall_if), 32'(if_req | !is_fetch));
      mem_ack   = c == ackdly;
      mem_rdata = (c == ackdly) ? val : $urandom;
      @(negedge clk);
      mem_ack = 1'b0;
      c++;
      done = dm_done | if_valid;
    end
    chk("latency", 32'(c), 32'((to ? TO - 1 : ackdly) + 1));
    chk("dm_done", 32'(dm_done), 32'(!is_fetch));
    chk("if_valid", 32'(if_valid), 32'(is_fetch));
    chk("err", 32'(err), 32'(to));
    chk("req_drop", 32'(mem_req), 32'd0);
    chk(is_fetch ? "if_rdata" : "dm_rdata", is_fetch ? if_rdata : dm_rdata, exp_d);
    chk("stall_mem_done", 32'(stall_mem), 32'd0);
    chk("stall_if_done", 32'(stall_if), 32'(is_fetch ? 1'b0 : if_req));
  endtask

  // kind: 0 load, 1 store, 2 fetch, 3 data access racing a fetch
  task automatic txn(input int kind, input bit we, input bit both, input logic [31:0] da,
                     input logic [31:0] wd, input logic [31:0] fa, input int d1, input int d2,
                     input logic [31:0] v1, input logic [31:0] v2);
    if (kind != 2) begin
      dm_read  = !we || both;
      dm_write = we;
      dm_addr  = da;
      dm_wdata = wd;
    end
    if (kind >= 2) begin
      if_req  = 1'b1;
      if_addr = fa;
    end
    if (kind != 2) begin
      serve(1'b0, we, da, wd, d1, v1);
      @(negedge clk);
      chk("no_reissue_data", 32'(mem_req), 32'd0);
      dm_read  = 1'b0;
      dm_write = 1'b0;
    end
    if (kind >= 2) begin
      serve(1'b1, 1'b0, fa, 32'h0, d2, v2);
      @(negedge clk);
      chk("no_reissue_fetch", 32'(mem_req), 32'd0);
      if_req = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      mem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("idle_req", 32'(mem_req), 32'd0);
      chk("idle_pulse", 32'(dm_done | if_valid | err), 32'd0);
    end
  endtask

  initial begin
    #3;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_pulses", 32'(dm_done | if_valid | err), 32'd0);
    chk("rst_stalls", 32'(stall_if | stall_mem), 32'd0);
    chk("rst_data", if_rdata | dm_rdata | mem_addr | mem_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    txn(0, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 3, 0, 32'hDEADBEEF, 32'h0);
    idle(1);
    txn(1, 1'b1, 1'b0, 32'h100, 32'h12345678, 32'h0, 0, 0, 32'hFFFFFFFF, 32'h0);
    idle(1);
    txn(3, 1'b0, 1'b0, 32'h200, 32'h0, 32'h1000, 1, 2, 32'hCAFEF00D, 32'h00A00093);
    txn(2, 1'b0, 1'b0, 32'h0, 32'h0, 32'h1004, 0, 9, 32'h0, 32'h12345677);
    txn(0, 1'b0, 1'b0, 32'h44, 32'h0, 32'h0, TO - 1, 0, 32'h55AA55AA, 32'h0);
    txn(2, 1'b0, 1'b0, 32'h0, 32'h0, 32'h1008, 0, TO - 1, 32'h0, 32'h0badf00d);
    txn(1, 1'b1, 1'b1, 32'h48, 32'h77777777, 32'h0, 1, 0, 32'h11111111, 32'h0);
    dm_read = 1'b1;
    dm_addr = 32'h300;
    @(negedge clk);
    chk("pre_rst_req", 32'(mem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_req", 32'(mem_req), 32'd0);
    chk("async_rst_stall", 32'(stall_mem), 32'd0);
    chk("async_rst_done", 32'(dm_done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    serve(1'b0, 1'b0, 32'h300, 32'h0, 1, 32'h13579BDF);
    @(negedge clk);
    dm_read = 1'b0;
    idle(1);
    for (int i = 0; i < 80; i++) begin
      int kind = $urandom_range(0, 3);
      bit we = (kind == 1) || (kind == 3 && $urandom_range(0, 1) == 1);
      txn(kind, we, $urandom_range(0, 3) == 0, $urandom, $urandom, $urandom,
          $urandom_range(0, 5), $urandom_range(0, 5), $urandom, $urandom);
      idle($urandom_range(0, 2));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
